ms_row_loader: RTL



---
 rtl/ms_row_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ms_row_loader.sv
// Row loader for the margin-sampling core: packs N_CLASSES scores per sample into one
// BRAM row, stores N_SAMPLES rows, then launches the core and waits for it to finish.
module ms_row_loader #(
  parameter int N_CLASSES = 10,
  parameter int N_SAMPLES = 1024,
  parameter int SCORE_W   = 16,
  parameter int ROW_W     = 256,
  parameter int ROW_BYTES = ROW_W / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [SCORE_W-1:0]             s_data,
  input  logic                           s_last,
  input  logic                           err_clr,
  output logic                           bram_en,
  output logic [ROW_W/8-1:0]             bram_we,
  output logic [31:0]                    bram_addr,
  output logic [ROW_W-1:0]               bram_din,
  output logic                           ms_start,
  input  logic                           ms_ready,
  output logic                           busy,
  output logic                           batch_done,
  output logic [$clog2(N_SAMPLES):0]     rows_written,
  output logic                           err_len
);

  localparam int RW_W   = $clog2(N_SAMPLES) + 1;
  localparam int LANE_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam int DATA_W = N_CLASSES * SCORE_W;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_CLASSES - 1);
  localparam logic [RW_W-1:0]   ROWS_MAX  = RW_W'(N_SAMPLES);

  localparam logic [2:0] FILL      = 3'd0;
  localparam logic [2:0] WRITE     = 3'd1;
  localparam logic [2:0] KICK      = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  // Forces every lane at or above N_CLASSES to zero.
  function automatic logic [ROW_W-1:0] row_mask(input logic [ROW_W-1:0] row);
    logic [ROW_W-1:0] m;
    for (int i = 0; i < ROW_W; i++) begin
      m[i] = (i < DATA_W) ? row[i] : 1'b0;
    end
    return m;
  endfunction

  logic [2:0]         state_r, state_nxt_s;
  logic [LANE_W-1:0]  lane_r, lane_nxt_s;
  logic [ROW_W-1:0]   buf_r, buf_nxt_s, row_s;
  logic [RW_W-1:0]    rows_r, rows_nxt_s;
  logic               err_set_s, err_nxt_s, done_nxt_s;
  logic               s_ready_r, busy_r, bram_en_r, batch_done_r, err_r;
  logic [ROW_W/8-1:0] bram_we_r;
  logic [31:0]        bram_addr_r;
  logic [ROW_W-1:0]   bram_din_r;

  // Buffer with the currently offered score dropped into its lane.
  always_comb begin
    row_s = buf_r;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (lane_r == LANE_W'(i)) begin
        row_s[i*SCORE_W +: SCORE_W] = s_data;
      end else begin
        row_s[i*SCORE_W +: SCORE_W] = buf_r[i*SCORE_W +: SCORE_W];
      end
    end
  end

  // Next-state, lane, buffer, row-count and error-set decisions.
  always_comb begin
    state_nxt_s = state_r;
    lane_nxt_s  = lane_r;
    buf_nxt_s   = buf_r;
    rows_nxt_s  = rows_r;
    err_set_s   = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      FILL: begin
        if (s_valid) begin
          if (lane_r == LAST_LANE) begin
            // Row is complete; row_s is captured into bram_din on this edge.
            state_nxt_s = WRITE;
            lane_nxt_s  = '0;
            buf_nxt_s   = '0;
            err_set_s   = ~s_last;
          end else if (s_last) begin
            lane_nxt_s = '0;
            buf_nxt_s  = '0;
            err_set_s  = 1'b1;
          end else begin
            lane_nxt_s = lane_r + LANE_W'(1);
            buf_nxt_s  = row_s;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      WRITE: begin
        rows_nxt_s = rows_r + RW_W'(1);
        if ((rows_r + RW_W'(1)) == ROWS_MAX) begin
          state_nxt_s = KICK;
        end else begin
          state_nxt_s = FILL;
        end
      end
      KICK: begin
        if (ms_ready) begin
          state_nxt_s = WAIT_BUSY;
        end else begin
          state_nxt_s = KICK;
        end
      end
      WAIT_BUSY: begin
        if (!ms_ready) begin
          state_nxt_s = WAIT_DONE;
        end else begin
          state_nxt_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (ms_ready) begin
          state_nxt_s = FILL;
          rows_nxt_s  = '0;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = FILL;
        lane_nxt_s  = '0;
        buf_nxt_s   = '0;
        rows_nxt_s  = '0;
      end
    endcase
  end

  // Sticky length error; a clear wins over a set in the same cycle.
  always_comb begin
    if (err_clr) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r | err_set_s;
    end
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FILL;
      lane_r       <= '0;
      buf_r        <= '0;
      rows_r       <= '0;
      err_r        <= 1'b0;
      s_ready_r    <= 1'b1;
      busy_r       <= 1'b0;
      bram_en_r    <= 1'b0;
      bram_we_r    <= '0;
      bram_addr_r  <= 32'd0;
      bram_din_r   <= '0;
      batch_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lane_r       <= lane_nxt_s;
      buf_r        <= buf_nxt_s;
      rows_r       <= rows_nxt_s;
      err_r        <= err_nxt_s;
      s_ready_r    <= (state_nxt_s == FILL);
      busy_r       <= (state_nxt_s != FILL);
      bram_en_r    <= (state_nxt_s == WRITE);
      bram_we_r    <= (state_nxt_s == WRITE) ? '1 : '0;
      bram_addr_r  <= (state_nxt_s == WRITE) ? (32'(rows_r) * 32'(ROW_BYTES)) : 32'd0;
      bram_din_r   <= (state_nxt_s == WRITE) ? row_mask(row_s) : '0;
      batch_done_r <= done_nxt_s;
    end
  end

  // The start pulse must land in the same cycle the core reports idle.
  assign ms_start     = (state_r == KICK) && ms_ready;
  assign s_ready      = s_ready_r;
  assign busy         = busy_r;
  assign bram_en      = bram_en_r;
  assign bram_we      = bram_we_r;
  assign bram_addr    = bram_addr_r;
  assign bram_din     = bram_din_r;
  assign batch_done   = batch_done_r;
  assign rows_written = rows_r;
  assign err_len      = err_r;

endmodule
